pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the BRISC core, the next generation of the fetch-address controller. It holds the instruction address, advances it once per clock while the program is loaded and not halted, and redirects it on absolute jump, PC-relative branch, subroutine call and return. A hardware return-address stack supports nested calls. It sits between the instruction decoder (redirect requests) and the instruction memory (read address).

## Interface
Parameters:
- ADDR_W, 8, program-counter / instruction-address width (≥ 2)
- STACK_DEPTH, 4, return-address stack entries (≥ 1)

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- load_done  in  1  program memory loaded; sequencing is enabled only while 1
- halt  in  1  freeze PC and stack while 1
- jump_en  in  1  absolute jump request
- jump_address  in  ADDR_W  target for jump_en and call_en
- branch_en  in  1  relative branch request
- branch_offset  in  ADDR_W  two's-complement offset added to current PC
- call_en  in  1  push return address, go to jump_address
- ret_en  in  1  pop return address into PC
- program_counter  out  ADDR_W  current fetch address
- state  out  2  IDLE=0, RUN=1, HALTED=2, END=3
- stack_level  out  clog2(STACK_DEPTH+1)  number of valid stack entries
- stack_err  out  1  sticky: overflow or underflow occurred

## Operation
- States: IDLE → RUN when load_done=1. RUN → HALTED when halt=1; HALTED → RUN when halt=0. RUN → END when PC reaches all-ones (2^ADDR_W−1) by any update. END is terminal until reset. load_done falling to 0 in RUN or HALTED → IDLE, PC and stack retained.
- In RUN with halt=0, exactly one action per cycle, priority: ret_en > call_en > jump_en > branch_en > increment.
- Increment: PC ← PC+1.
- Jump: PC ← jump_address.
- Branch: PC ← (PC + branch_offset) mod 2^ADDR_W; wrap in both directions, no error.
- Call: if stack_level < STACK_DEPTH, push PC+1 (mod 2^ADDR_W), PC ← jump_address. If full: overflow — no push, PC ← PC+1, stack_err ← 1.
- Ret: if stack_level > 0, PC ← top entry, pop. If empty: underflow — PC ← PC+1, stack_err ← 1.
- Lower-priority requests in the same cycle are discarded, not queued.
- In IDLE, HALTED, END: PC, stack and stack_level hold; all requests ignored; stack_err unchanged.
- stack_err cleared only by reset.

## Timing
- Reset (asynchronous, immediate on RST_N=0): program_counter=0, state=IDLE, stack_level=0, stack_err=0, stack contents cleared to 0. Reset mid-call/branch discards the operation.
- All outputs registered; no combinational input→output paths.
- IDLE→RUN: edge with load_done=1 changes state only; first PC update occurs on the following edge.
- RUN→HALTED: the edge sampling halt=1 performs no PC update; on the edge sampling halt=0 state returns to RUN, PC advances from the next edge.
- Redirect latency: request sampled at edge N → new PC visible after edge N. Call/ret stack_level updates on the same edge.
- Reaching all-ones: PC and state=END update on the same edge; PC holds at all-ones thereafter.
- Back-to-back call/ret every cycle supported with no bubbles.

## Test plan
- Reset then load_done=1, no requests: state IDLE→RUN, PC 0,1,2,…,255 then state=END, PC holds 255 (ADDR_W=8).
- PC=10, branch_offset=0xFB (−5) → PC=5; PC=250, branch_offset=10 → PC=4 (wrap), stack_err stays 0.
- PC=3, call_en with jump_address=40 → PC=40, stack_level=1; ret_en at PC=42 → PC=4, stack_level=0.
- STACK_DEPTH=4: five nested calls → fifth gives PC+1, stack_level=4, stack_err=1; ret on empty stack after unwinding → PC+1, stack_err stays 1.
- Same cycle ret_en, call_en, jump_en, branch_en with stack_level=1 → ret taken only; halt=1 for 3 cycles mid-run → PC and stack frozen, resume at PC+1.
- Assert RST_N=0 between edges during a call → outputs return to reset values immediately, no push recorded.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address controller with a hardware return-address stack.
// Ports: CLK/RST_N, load_done/halt gating, jump/branch/call/ret requests in;
//   program_counter, state, stack_level, stack_err out (all registered).
module pc_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load_done,
  input  logic              halt,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_address,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              call_en,
  input  logic              ret_en,
  output logic [ADDR_W-1:0] program_counter,
  output logic [1:0]        state,
  output logic [LVL_W-1:0]  stack_level,
  output logic              stack_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, top;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic              err_q, err_d, push;
  logic              full, empty;
  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];

  assign pc_inc = pc_q + ADDR_W'(1);
  assign full   = (lvl_q == LVL_W'(STACK_DEPTH));
  assign empty  = (lvl_q == '0);

  // Entry just below the current level is the top of stack.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (LVL_W'(i + 1) == lvl_q) top = stk_q[i];
  end

  // One action per RUN cycle: ret > call > jump > branch > increment.
  always_comb begin
    pc_d  = pc_inc;
    lvl_d = lvl_q;
    err_d = err_q;
    push  = 1'b0;
    if (ret_en) begin
      if (!empty) begin
        pc_d  = top;
        lvl_d = lvl_q - LVL_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (call_en) begin
      if (!full) begin
        push  = 1'b1;
        pc_d  = jump_address;
        lvl_d = lvl_q + LVL_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (jump_en) begin
      pc_d = jump_address;
    end else if (branch_en) begin
      pc_d = pc_q + branch_offset;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      lvl_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (load_done) state_q <= S_RUN;
        end
        S_RUN: begin
          if (!load_done) begin
            state_q <= S_IDLE;
          end else if (halt) begin
            state_q <= S_HALTED;
          end else begin
            pc_q  <= pc_d;
            lvl_q <= lvl_d;
            err_q <= err_d;
            if (push)
              for (int i = 0; i < STACK_DEPTH; i++)
                if (LVL_W'(i) == lvl_q) stk_q[i] <= pc_inc;
            if (&pc_d) state_q <= S_END;
          end
        end
        S_HALTED: begin
          if (!load_done)  state_q <= S_IDLE;
          else if (!halt)  state_q <= S_RUN;
        end
        S_END: begin
          state_q <= S_END;
        end
      endcase
    end
  end

  assign program_counter = pc_q;
  assign state           = state_q;
  assign stack_level     = lvl_q;
  assign stack_err       = err_q;

endmodule
